// File: rtl/pwm_pkg.sv
// pwm_pkg
//   Shared definitions for the multi-channel PWM generator: channel mode
//   and ramp direction encodings, plus a helper that builds the all-ones
//   value for a given duty/counter width.
package pwm_pkg;

   // Channel operating mode: fixed duty or autonomous triangle ramp
   typedef enum logic {
      PWM_STATIC  = 1'b0,
      PWM_BREATHE = 1'b1
   } pwm_mode_e;

   // Ramp direction used while breathing
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_e;

   // All-ones value of a w-bit quantity (1 <= w <= 32), returned in 32 bits
   function automatic logic [31:0] all_ones(input int w);
      return 32'hFFFF_FFFF >> (32 - w);
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
//   One PWM output. Holds the host-written shadow duty/mode, a pending flag,
//   the active duty/mode used for comparison, and the breathe direction.
//   The active settings only change at period boundaries so the output never
//   glitches mid-period.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   wr_en         write strobe already decoded for this channel
//   wr_duty       requested duty / breathe start value
//   wr_mode       0 = static, 1 = breathe
//   boundary      high for the single cycle that ends a period
//   cnt           shared period counter
//   pwm           registered PWM output
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_duty,
   input  logic             wr_mode,
   input  logic             boundary,
   input  logic [WIDTH-1:0] cnt,
   output logic             pwm
);

   localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(all_ones(WIDTH));

   logic [WIDTH-1:0] shadow_duty;
   pwm_mode_e        shadow_mode;
   logic             pending;
   logic [WIDTH-1:0] active_duty;
   pwm_mode_e        active_mode;
   pwm_dir_e         dir;

   // Shadow capture and boundary update. The boundary acts on the state as
   // it was before this cycle's write; a coincident write only refills the
   // shadow and re-arms pending, so it is applied one period later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_duty <= '0;
         shadow_mode <= PWM_STATIC;
         pending     <= 1'b0;
         active_duty <= '0;
         active_mode <= PWM_STATIC;
         dir         <= DIR_UP;
      end else begin
         if (boundary) begin
            if (pending) begin
               active_duty <= shadow_duty;
               active_mode <= shadow_mode;
               dir         <= DIR_UP;
               pending     <= 1'b0;
            end else if (active_mode == PWM_BREATHE) begin
               // Triangle ramp: turn around at the ends so each extreme is
               // held for exactly one period
               if (dir == DIR_UP && active_duty == DUTY_MAX) begin
                  dir         <= DIR_DOWN;
                  active_duty <= DUTY_MAX - 1'b1;
               end else if (dir == DIR_DOWN && active_duty == '0) begin
                  dir         <= DIR_UP;
                  active_duty <= {{(WIDTH-1){1'b0}}, 1'b1};
               end else if (dir == DIR_UP) begin
                  active_duty <= active_duty + 1'b1;
               end else begin
                  active_duty <= active_duty - 1'b1;
               end
            end
         end
         if (wr_en) begin
            shadow_duty <= wr_duty;
            shadow_mode <= pwm_mode_e'(wr_mode);
            pending     <= 1'b1;
         end
      end
   end

   // Output compare. All-ones is forced high so full duty really is 100%
   // rather than one count short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm <= 1'b0;
      end else begin
         pwm <= (active_duty == DUTY_MAX) ? 1'b1 : (cnt < active_duty);
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi
//   Multi-channel PWM generator. A prescaler divides clk down to counter
//   ticks, a shared period counter runs over 2^WIDTH ticks, and each channel
//   compares its active duty against that counter.
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   wr_en         write strobe, one cycle per write
//   wr_chan       target channel; out-of-range values are ignored
//   wr_duty       requested duty / breathe start value
//   wr_mode       0 = static, 1 = breathe
//   pwm           registered PWM outputs, one per channel
//   period_tick   one-cycle pulse after each period boundary
module pwm_multi
   import pwm_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 8,
   parameter  int PRESCALE = 188,
   localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [CHW-1:0]      wr_chan,
   input  logic [WIDTH-1:0]    wr_duty,
   input  logic                wr_mode,
   output logic [CHANNELS-1:0] pwm,
   output logic                period_tick
);

   localparam int               PSW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PSW-1:0]   PRE_LAST = PSW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(all_ones(WIDTH));

   logic [PSW-1:0]   pre_cnt;
   logic [WIDTH-1:0] cnt;
   logic             tick_en;
   logic             boundary;
   logic             wr_valid;

   assign tick_en  = (pre_cnt == PRE_LAST);
   assign boundary = tick_en && (cnt == CNT_MAX);
   assign wr_valid = wr_en && (int'(wr_chan) < CHANNELS);

   // Prescaler and period counter; the period counter wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         cnt     <= '0;
      end else begin
         if (tick_en) begin
            pre_cnt <= '0;
            cnt     <= cnt + 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
      end
   end

   // Registered boundary strobe for the host
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         period_tick <= 1'b0;
      end else begin
         period_tick <= boundary;
      end
   end

   // One channel per output, each receiving its own decoded write strobe
   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic ch_wr;
      assign ch_wr = wr_valid && (wr_chan == CHW'(i));

      pwm_channel #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (ch_wr),
         .wr_duty  (wr_duty),
         .wr_mode  (wr_mode),
         .boundary (boundary),
         .cnt      (cnt),
         .pwm      (pwm[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi
//   Directed bench for pwm_multi with CHANNELS=4, WIDTH=4, PRESCALE=2
//   (32-clk period). A second CHANNELS=3 instance shares the same inputs,
//   so every write to channel 3 is an out-of-range write for it.
module tb_pwm_multi;

   localparam int PERIOD = 32;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [1:0] wr_chan;
   logic [3:0] wr_duty;
   logic       wr_mode;
   logic [3:0] pwm;
   logic       period_tick;
   logic [2:0] pwm3;
   logic       period_tick3;

   int   vectors     = 0;
   int   miscompares = 0;
   int   hiCnt[4];
   int   hiCnt3[3];
   int   tickCnt;
   logic lastTick;

   pwm_multi #(.CHANNELS(4), .WIDTH(4), .PRESCALE(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_chan     (wr_chan),
      .wr_duty     (wr_duty),
      .wr_mode     (wr_mode),
      .pwm         (pwm),
      .period_tick (period_tick)
   );

   pwm_multi #(.CHANNELS(3), .WIDTH(4), .PRESCALE(2)) dut3 (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_chan     (wr_chan),
      .wr_duty     (wr_duty),
      .wr_mode     (wr_mode),
      .pwm         (pwm3),
      .period_tick (period_tick3)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence gets lost
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison point
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Present one write on the bus (cleared by the caller a cycle later)
   task automatic applyStimulus(input logic [1:0] chan, input logic [3:0] duty,
                                input logic mode);
      wr_en   = 1'b1;
      wr_chan = chan;
      wr_duty = duty;
      wr_mode = mode;
   endtask

   // Sample one full period, starting just after a period_tick sample and
   // ending on the next one; optionally issue a write after sample wrAt
   task automatic measurePeriod(input bit doWrite, input int wrAt,
                                input logic [1:0] chan, input logic [3:0] duty,
                                input logic mode);
      for (int c = 0; c < 4; c++) hiCnt[c] = 0;
      for (int c = 0; c < 3; c++) hiCnt3[c] = 0;
      tickCnt = 0;
      for (int k = 1; k <= PERIOD; k++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) if (pwm[c] === 1'b1) hiCnt[c]++;
         for (int c = 0; c < 3; c++) if (pwm3[c] === 1'b1) hiCnt3[c]++;
         if (period_tick === 1'b1) tickCnt++;
         lastTick = period_tick;
         if (doWrite && k == wrAt) applyStimulus(chan, duty, mode);
         if (k == wrAt + 1) wr_en = 1'b0;
      end
   endtask

   // Compare the last measured period against hand-computed high counts
   task automatic checkPeriod(input string tag, input int e0, input int e1,
                              input int e2, input int e3);
      checkOutput({tag, ".ch0"}, hiCnt[0], e0);
      checkOutput({tag, ".ch1"}, hiCnt[1], e1);
      checkOutput({tag, ".ch2"}, hiCnt[2], e2);
      checkOutput({tag, ".ch3"}, hiCnt[3], e3);
      checkOutput({tag, ".c3_ch0"}, hiCnt3[0], e0);
      checkOutput({tag, ".c3_ch1"}, hiCnt3[1], e1);
      checkOutput({tag, ".c3_ch2"}, hiCnt3[2], e2);
      checkOutput({tag, ".ticks"}, tickCnt, 1);
      checkOutput({tag, ".tick_last"}, lastTick, 1'b1);
   endtask

   // Count clocks from reset release to the first period_tick
   task automatic waitFirstTick(input string tag);
      int n;
      n = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (period_tick === 1'b1) begin
            n = k;
            break;
         end
      end
      checkOutput({tag, ".first_tick"}, n, PERIOD);
   endtask

   // Directed sequence
   initial begin
      wr_en   = 1'b0;
      wr_chan = 2'd0;
      wr_duty = 4'd0;
      wr_mode = 1'b0;
      rst     = 1'b0;
      #1 rst  = 1'b1;

      $display("[TB] reset phase");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("reset.pwm", pwm, 4'b0000);
         checkOutput("reset.tick", period_tick, 1'b0);
         checkOutput("reset.pwm3", pwm3, 3'b000);
      end
      rst = 1'b0;
      waitFirstTick("reset");

      $display("[TB] static and extremes");
      measurePeriod(1, 3, 2'd0, 4'd4, 1'b0);
      checkPeriod("m1_pending", 0, 0, 0, 0);
      measurePeriod(1, 3, 2'd1, 4'd15, 1'b0);
      checkPeriod("m2_ch0_d4", 8, 0, 0, 0);
      measurePeriod(1, 3, 2'd1, 4'd0, 1'b0);
      checkPeriod("m3_ch1_d15", 8, 32, 0, 0);
      measurePeriod(1, 3, 2'd2, 4'd8, 1'b0);
      checkPeriod("m4_ch1_d0", 8, 0, 0, 0);

      $display("[TB] update timing");
      measurePeriod(1, 16, 2'd2, 4'd2, 1'b0);
      checkPeriod("m5_ch2_d8", 8, 0, 16, 0);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m6_ch2_d2", 8, 0, 4, 0);
      measurePeriod(1, 31, 2'd2, 4'd6, 1'b0);
      checkPeriod("m7_boundary_wr", 8, 0, 4, 0);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m8_wr_deferred", 8, 0, 4, 0);

      $display("[TB] breathe");
      measurePeriod(1, 3, 2'd3, 4'd14, 1'b1);
      checkPeriod("m9_ch2_d6", 8, 0, 12, 0);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m10_br14", 8, 0, 12, 28);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m11_br15", 8, 0, 12, 32);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m12_br14", 8, 0, 12, 28);
      measurePeriod(1, 3, 2'd3, 4'd0, 1'b1);
      checkPeriod("m13_br13", 8, 0, 12, 26);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m14_br0", 8, 0, 12, 0);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m15_br1", 8, 0, 12, 2);
      measurePeriod(1, 10, 2'd3, 4'd5, 1'b0);
      checkPeriod("m16_br2", 8, 0, 12, 4);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m17_static5", 8, 0, 12, 10);
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("m18_hold5", 8, 0, 12, 10);

      $display("[TB] async reset");
      for (int k = 0; k < 4; k++) @(negedge clk);
      checkOutput("async.pre_ch0", pwm[0], 1'b1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async.pwm", pwm, 4'b0000);
      checkOutput("async.pwm3", pwm3, 3'b000);
      checkOutput("async.tick", period_tick, 1'b0);
      for (int k = 0; k < 3; k++) @(negedge clk);
      rst = 1'b0;
      waitFirstTick("post_reset");
      measurePeriod(0, 0, 2'd0, 4'd0, 1'b0);
      checkPeriod("post_reset", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM generator. It is the successor to the single-channel blink PWM and drives N LED/actuator outputs from the 48 MHz fabric clock. Each channel has a runtime-writable duty cycle, applied glitch-free at period boundaries, and an optional autonomous "breathe" mode that ramps the duty up and down. It sits between the host register/control logic and the output pins.

## Interface
- CHANNELS, 4, number of PWM outputs (≥1)
- WIDTH, 8, duty/counter resolution in bits (≥2); period = 2^WIDTH ticks
- PRESCALE, 188, clk cycles per counter tick (≥1); defaults give ≈1 kHz at 48 MHz
- CHW, derived localparam, $clog2(CHANNELS) (minimum 1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write strobe, one cycle per write
- wr_chan  in  CHW  target channel; values ≥CHANNELS are ignored
- wr_duty  in  WIDTH  requested duty / breathe start value
- wr_mode  in  1  0 = static, 1 = breathe
- pwm  out  CHANNELS  registered PWM outputs
- period_tick  out  1  one-cycle pulse at each period boundary

## Operation
- Prescaler: counts 0..PRESCALE-1 and asserts tick_en on PRESCALE-1, then wraps. With PRESCALE=1, tick_en is asserted every cycle.
- Period counter cnt (WIDTH bits): increments on tick_en and wraps all-ones→0.
- Boundary: tick_en && cnt == all-ones. period_tick is registered high for exactly one cycle.
- Per channel state: shadow duty and mode, pending flag, active duty and mode, direction bit (up/down).
- Write: on wr_en with a valid wr_chan, shadow ← wr_duty/wr_mode and pending ← 1. A later write before the boundary overwrites the earlier one; the last write wins.
- At the boundary, per channel:
  - If pending: active ← shadow, dir ← up, pending ← 0.
  - Else if active mode is breathe:
    - dir up and duty == all-ones → dir ← down, duty ← all-ones-1.
    - dir down and duty == 0 → dir ← up, duty ← 1.
    - Otherwise duty ± 1.
  - Else (static): hold.
- A write in the same cycle as the boundary lands in shadow only. The boundary uses the pre-write state, so the write takes effect one period later.
- Compare: pwm[i] ← (active_duty == all-ones) ? 1 : (cnt < active_duty).
  - duty 0 gives a constant low output.
  - duty all-ones gives a constant high output.
  - A 2^W-2 high-count duty is the largest duty below 100%.
- Reset values: all counters 0, shadow/active duty 0, mode static, pending 0, dir up, pwm all 0, period_tick 0.
- Mid-operation reset clears everything immediately, with no clock required. The first boundary after release occurs PRESCALE·2^WIDTH cycles later.

## Timing
- Period is PRESCALE·2^WIDTH clk cycles. A static duty d gives d·PRESCALE high cycles per period.
- pwm is registered: it changes one clk after cnt changes. The period's high phase begins on the cycle after the boundary.
- Write-to-output latency: a new duty appears on the first period that starts after the next boundary. That is at most one period plus one cycle.
- A full breathe triangle (0→max→0) takes 2·(2^WIDTH-1) periods.
- There is no backpressure, and wr_en is accepted every cycle.

## Structure
- Shared package pwm_pkg holds:
  - mode constants PWM_STATIC=0 and PWM_BREATHE=1
  - direction constants DIR_UP/DIR_DOWN
  - the all-ones helper for WIDTH
- Top pwm_multi holds the prescaler, period counter, boundary/period_tick logic and write decode.
- Sub-module pwm_channel (WIDTH parameter) holds shadow, pending, active, direction and compare. It is instantiated CHANNELS times via generate.

## Test plan
Bench parameters are CHANNELS=4, WIDTH=4, PRESCALE=2, giving a 32-clk period.
- Reset: hold rst for 5 cycles, then release. Required response:
  - pwm = 0 and period_tick = 0 throughout reset.
  - First period_tick 32 clks after release, one cycle wide, then every 32 clks.
- Static write: ch0 duty 4.
  - From the period after the next boundary, pwm[0] is high 8 clk of every 32.
  - pwm[3:1] stay 0.
- Extremes:
  - ch1 duty 0 → pwm[1] is constantly 0.
  - ch1 duty 15 → pwm[1] is constantly 1 for the whole period.
- Update timing:
  - ch2 at 8, rewritten to 2 mid-period: the current period is 16 clk high and the next is 4 clk high.
  - A write coincident with period_tick applies one period later.
- Breathe:
  - ch3 mode 1, start 14 → successive period duties are 14, 15, 14, 13.
  - Start 0 → 0, 1, 2.
  - A static write mid-ramp stops the ramp at the next boundary.
- Async reset and invalid channel:
  - rst asserted mid-high-phase between clk edges → pwm drops at once.
  - Variant CHANNELS=3: a write to wr_chan=3 leaves all outputs unchanged.
